// File: rtl/register_file_if.sv
`default_nettype none
// ============================================================================
// Module      : register_file_if
// Description : Write, read and error-monitor signal bundle for register_file.
//               master = writeback/decode side, slave = the register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface register_file_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) ();
    logic             w_en;
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_data;
    logic [AW-1:0]    ra_addr;
    logic [WIDTH-1:0] ra_data;
    logic [AW-1:0]    rb_addr;
    logic [WIDTH-1:0] rb_data;
    logic             err_clr;
    logic             err;
    logic [AW-1:0]    err_addr;
    logic [7:0]       wr_cnt;

    modport master (
        output w_en, w_addr, w_data, ra_addr, rb_addr, err_clr,
        input  ra_data, rb_data, err, err_addr, wr_cnt
    );

    modport slave (
        input  w_en, w_addr, w_data, ra_addr, rb_addr, err_clr,
        output ra_data, rb_data, err, err_addr, wr_cnt
    );
endinterface
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : DEPTH x WIDTH register file, one addressed write port, two
//               combinational read ports, sticky clearable write-error
//               monitor and a saturating accepted-write counter.
//               Optional macro REGISTER_FILE_BYPASS_EN enables write-through
//               forwarding of an accepted write to the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int ZERO_REG = 0
) (
    input  wire logic       clk,
    input  wire logic       rst,    // asynchronous, active-low
    register_file_if.slave  bus
);
    localparam int         NSLOT   = 2 ** AW;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    // Address classification of the current write request
    logic w_in_range;
    logic w_fault;
    logic w_accept;

    assign w_in_range = ({1'b0, bus.w_addr} < DEPTH_C);
    assign w_fault    = bus.w_en && !w_in_range;
    assign w_accept   = bus.w_en && w_in_range &&
                        !((ZERO_REG != 0) && (bus.w_addr == '0));

    // Every decodable address has a slot; unimplemented ones read as zero,
    // so the read muxes need no separate range check.
    logic [WIDTH-1:0] slot [NSLOT];

    genvar i;
    generate
        for (i = 0; i < NSLOT; i++) begin : g_slot
            if ((i >= DEPTH) || ((i == 0) && (ZERO_REG != 0))) begin : g_const
                assign slot[i] = '0;
            end else begin : g_reg
                logic [WIDTH-1:0] data_q;

                // Storage register, loaded when the decoded write hits it
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        data_q <= '0;
                    end else if (w_accept && (bus.w_addr == AW'(i))) begin
                        data_q <= bus.w_data;
                    end
                end

                assign slot[i] = data_q;
            end
        end
    endgenerate

    // Read ports, with optional forwarding of the write in flight
`ifdef REGISTER_FILE_BYPASS_EN
    assign bus.ra_data = (w_accept && (bus.ra_addr == bus.w_addr)) ? bus.w_data
                                                                   : slot[bus.ra_addr];
    assign bus.rb_data = (w_accept && (bus.rb_addr == bus.w_addr)) ? bus.w_data
                                                                   : slot[bus.rb_addr];
`else
    assign bus.ra_data = slot[bus.ra_addr];
    assign bus.rb_data = slot[bus.rb_addr];
`endif

    // Error monitor and write counter state
    logic          err_q,      err_d;
    logic [AW-1:0] err_addr_q, err_addr_d;
    logic [7:0]    wr_cnt_q,   wr_cnt_d;

    // Next-state: clear first, then a same-edge fault overrides the clear
    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        wr_cnt_d   = wr_cnt_q;

        if (bus.err_clr) begin
            err_d      = 1'b0;
            err_addr_d = '0;
            wr_cnt_d   = '0;
        end else if (w_accept && (wr_cnt_q != 8'hFF)) begin
            wr_cnt_d   = wr_cnt_q + 8'd1;
        end

        if (w_fault) begin
            err_d = 1'b1;
            // Only the first fault since the last clear is recorded
            if (!err_q || bus.err_clr) begin
                err_addr_d = bus.w_addr;
            end
        end
    end

    // Monitor/counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
            wr_cnt_q   <= '0;
        end else begin
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    assign bus.err      = err_q;
    assign bus.err_addr = err_addr_q;
    assign bus.wr_cnt   = wr_cnt_q;

endmodule
`default_nettype wire

// File: doc/register_file.md
# register_file

Parametrised multi-register storage block: DEPTH registers of WIDTH bits with one addressed write port, two independent read ports, and a sticky, clearable write-error monitor. It generalises the single 8-bit register stage: the per-register chip select is replaced by an address decoder. It sits between the CPU decode stage, which provides the read addresses, and the writeback stage, which provides the write port.

## Interface
Parameters:
- WIDTH, 8, data bits per register (1..64)
- DEPTH, 8, number of registers (2..256; need not be a power of two)
- AW, 3, address width; must satisfy 2^AW >= DEPTH
- ZERO_REG, 0, when 1, register 0 is hard-wired to zero and writes to it are ignored

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-low
- w_en  in  1  write request
- w_addr  in  AW  write address
- w_data  in  WIDTH  write data
- ra_addr  in  AW  read port A address
- ra_data  out  WIDTH  read port A data
- rb_addr  in  AW  read port B address
- rb_data  out  WIDTH  read port B data
- err_clr  in  1  clears the sticky error state
- err  out  1  sticky error flag
- err_addr  out  AW  address of the first faulting write since the last clear
- wr_cnt  out  8  count of accepted writes, saturating at 255

## Operation
- Reset (rst low, asynchronous): all registers go to 0, err=0, err_addr=0, wr_cnt=0.
- Write: on the rising clk edge with w_en=1 and w_addr<DEPTH, register[w_addr] takes w_data.
  - When ZERO_REG=1 and w_addr=0, the write is discarded.
  - Otherwise the write is accepted and wr_cnt increments, saturating at 255.
- Faulting write: w_en=1 with w_addr>=DEPTH.
  - No register changes and wr_cnt is not incremented.
  - err is set to 1.
  - If err was 0 before this edge, err_addr captures w_addr. Later faults do not overwrite err_addr.
- err_clr=1 on an edge: err goes to 0, err_addr goes to 0 and wr_cnt goes to 0.
  - If a faulting write occurs on the same edge, the fault wins: err=1 and err_addr takes the new address.
- A discarded write to register 0 (ZERO_REG=1) is not a fault.
- Reads are combinational: rX_data = register[rX_addr].
  - rX_addr>=DEPTH reads 0.
  - Register 0 reads 0 when ZERO_REG=1.
- Both read ports may address the same register, or the register being written, in the same cycle.

## Timing
- Write latency: 1 cycle. Data written at edge N is visible on the read ports after edge N, combinationally.
- Read latency: 0 cycles (combinational from address), unless the bypass is compiled in (see Configuration).
- err, err_addr and wr_cnt are registered and update on the edge that sees the event.
- Reset asserted mid-cycle takes effect immediately, regardless of clk. The first write after rst deasserts is accepted on the next rising edge.

## Configuration
- Macro: REGISTER_FILE_BYPASS_EN.
- Defined: when w_en=1, the write is accepted and rX_addr==w_addr, read port X returns w_data in the same cycle (write-through forwarding). A discarded write to register 0 or a faulting write is never forwarded.
- Undefined: read ports return the stored value only; the new data appears after the edge.

## Test plan
- Reset: drive rst=0 mid-cycle with registers non-zero -> immediately all reads are 0, err=0, err_addr=0, wr_cnt=0.
- Write/read (WIDTH=8, DEPTH=8): write 0xA5 to addr 3, then 0x5A to addr 7 -> next cycle ra_addr=3 gives 0xA5, rb_addr=7 gives 0x5A, wr_cnt=2.
- Fault capture (DEPTH=6, AW=3): write to addr 6, then to addr 7 -> err=1, err_addr=6, no register changed, wr_cnt unchanged. Then err_clr together with a write to addr 7 -> err=1, err_addr=7.
- ZERO_REG=1: write 0xFF to addr 0 -> ra_addr=0 reads 0, err=0, wr_cnt unchanged.
- Bypass (macro defined): reg 2 holds 0x11; in the same cycle write 0x22 to addr 2 with ra_addr=2 -> ra_data=0x22 before the edge. With the macro undefined -> ra_data=0x11 before the edge and 0x22 after it.
- Saturation: 300 accepted writes -> wr_cnt=255; err_clr -> wr_cnt=0.
